// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption core with on-the-fly key expansion, UNROLL rounds per clock.
// Optional round tap ports are enabled with `define AES_ROUND_TAP_EN.
module aes128_round_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
`ifdef AES_ROUND_TAP_EN
  ,
  output logic         tap_valid,
  output logic [3:0]   tap_round,
  output logic [127:0] tap_state
`endif
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_round_engine: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [127:0] st, rk, st_nxt, rk_nxt;
  logic [3:0]   rnd, last_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, with 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      v = gf_mul(v, v);
      if (i != 0) v = gf_mul(v, x);
      else        v = v;
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte i lives at [127-8i -: 8]; i = row + 4*col.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] sb, sr, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      if (!last) begin
        o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end else begin
        o[127-32*c -: 8] = a0;
        o[119-32*c -: 8] = a1;
        o[111-32*c -: 8] = a2;
        o[103-32*c -: 8] = a3;
      end
    end
    return o ^ k;
  endfunction

  assign last_rnd = rnd + 4'(UNROLL - 1);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign busy     = (state == RUN);

  always_comb begin
    st_nxt = st;
    rk_nxt = rk;
    for (int k = 0; k < UNROLL; k++) begin
      rk_nxt = key_expand(rk_nxt, rcon(rnd + 4'(k)));
      st_nxt = aes_round(st_nxt, rk_nxt, (rnd + 4'(k)) == 4'd10);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= 128'h0;
      rk        <= 128'h0;
      rnd       <= 4'd0;
      out_valid <= 1'b0;
      out_block <= 128'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_block ^ in_key;
            rk    <= in_key;
            rnd   <= 4'd1;
            state <= RUN;
          end
        end
        RUN: begin
          st <= st_nxt;
          rk <= rk_nxt;
          if (last_rnd == 4'd10) begin
            rnd       <= 4'd0;
            out_block <= st_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd <= rnd + 4'(UNROLL);
          end
        end
        DONE: begin
          // Retiring and accepting in the same cycle keeps back-to-back traffic bubble-free.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st    <= in_block ^ in_key;
              rk    <= in_key;
              rnd   <= 4'd1;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_ROUND_TAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n || state != RUN) begin
      tap_valid <= 1'b0;
      tap_round <= 4'd0;
      tap_state <= 128'h0;
    end else begin
      tap_valid <= 1'b1;
      tap_round <= last_rnd;
      tap_state <= st_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_aes128_round_engine.sv
// Directed bench for aes128_round_engine: four instances with UNROLL = 1, 2, 5, 10
// checked against FIPS-197 vectors, backpressure, mid-run reset and input isolation.
module tb_aes128_round_engine;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         out_ready;
  logic [127:0] in_block, in_key;
  logic [3:0]   iv, ir, ov, bz;
  logic [127:0] ob [4];
`ifdef AES_ROUND_TAP_EN
  logic [3:0]   tv;
  logic [3:0]   tr [4];
  logic [127:0] ts [4];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_round_engine #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
      .in_block(in_block), .in_key(in_key), .out_valid(ov[g]), .out_ready(out_ready),
      .out_block(ob[g]), .busy(bz[g])
`ifdef AES_ROUND_TAP_EN
      , .tap_valid(tv[g]), .tap_round(tr[g]), .tap_state(ts[g])
`endif
    );
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, ov[i]); end
      total++; if (ob[i] !== 128'h0) begin bad++; $display("FAIL reset_out_block[%0d]: got %h want 0", i, ob[i]); end
      total++; if (bz[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bz[i]); end
      total++; if (ir[i] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, ir[i]); end
    end
    rst_n = 1'b1;
  endtask

  // Accepts one block on instance idx; optionally scrambles inputs during RUN.
  task automatic encrypt(input int idx, input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] exp_ct, input int exp_lat, input bit scramble,
                         input string name);
    int cnt;
    @(negedge clk);
    in_key = key; in_block = pt; iv[idx] = 1'b1;
    total++; if (ir[idx] !== 1'b1) begin bad++; $display("FAIL %s_accept_ready: got %b want 1", name, ir[idx]); end
    @(negedge clk);
    iv[idx] = 1'b0;
    if (scramble) begin in_key = ~key; in_block = ~pt; end
    total++; if (bz[idx] !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", name, bz[idx]); end
    total++; if (ir[idx] !== 1'b0) begin bad++; $display("FAIL %s_run_ready: got %b want 0", name, ir[idx]); end
    cnt = 0;
    while (ov[idx] !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (scramble) begin in_key = in_key ^ 128'h1; in_block = in_block + 128'h3; end
    end
    total++; if (cnt != exp_lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, cnt, exp_lat); end
    total++; if (ob[idx] !== exp_ct) begin bad++; $display("FAIL %s_ct: got %h want %h", name, ob[idx], exp_ct); end
    @(negedge clk);
    total++; if (ov[idx] !== 1'b0) begin bad++; $display("FAIL %s_retire: got %b want 0", name, ov[idx]); end
  endtask

  task automatic test_backpressure();
    int cnt;
    out_ready = 1'b0;
    @(negedge clk);
    in_key = KEY1; in_block = PT1; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    cnt = 0;
    while (ov[0] !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    total++; if (cnt != 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", cnt); end
    for (int i = 0; i < 7; i++) begin
      iv[0] = 1'b1; in_key = 128'(i) ^ KEY2; in_block = ~PT2;
      @(negedge clk);
      total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1", ov[0]); end
      total++; if (ob[0] !== CT1) begin bad++; $display("FAIL bp_hold_block: got %h want %h", ob[0], CT1); end
      total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_hold_ready: got %b want 0", ir[0]); end
    end
    out_ready = 1'b1; in_key = KEY2; in_block = PT2;
    #1;
    total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL bp_ready_follow: got %b want 1", ir[0]); end
    @(negedge clk);
    iv[0] = 1'b0;
    total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", ov[0]); end
    total++; if (bz[0] !== 1'b1) begin bad++; $display("FAIL bp_rerun: got %b want 1", bz[0]); end
    cnt = 0;
    while (ov[0] !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    total++; if (cnt != 10) begin bad++; $display("FAIL bp2_latency: got %0d want 10", cnt); end
    total++; if (ob[0] !== CT2) begin bad++; $display("FAIL bp2_ct: got %h want %h", ob[0], CT2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_key = KEY1; in_block = PT1; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", ov[0]); end
    total++; if (ob[0] !== 128'h0) begin bad++; $display("FAIL midrst_block: got %h want 0", ob[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bz[0]); end
    total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ir[0]); end
    repeat (12) @(negedge clk);
    total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrst_no_output: got %b want 0", ov[0]); end
    encrypt(0, KEY2, PT2, CT2, 10, 1'b0, "after_reset");
  endtask

`ifdef AES_ROUND_TAP_EN
  task automatic test_tap();
    total++; if ({tv[0], tr[0], ts[0]} !== 133'h0) begin bad++; $display("FAIL tap_idle: got %b/%0d/%h want zeros", tv[0], tr[0], ts[0]); end
    @(negedge clk);
    in_key = KEY1; in_block = PT1; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    total++; if (tv[0] !== 1'b1) begin bad++; $display("FAIL tap_valid: got %b want 1", tv[0]); end
    total++; if (tr[0] !== 4'd1) begin bad++; $display("FAIL tap_round: got %0d want 1", tr[0]); end
    total++; if (ts[0] !== 128'h89d810e8855ace682d1843d8cb128fe4) begin bad++; $display("FAIL tap_state: got %h want 89d810e8855ace682d1843d8cb128fe4", ts[0]); end
    repeat (12) @(negedge clk);
    total++; if (ts[0] !== 128'h0) begin bad++; $display("FAIL tap_idle_after: got %h want 0", ts[0]); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iv = 4'b0000; out_ready = 1'b1; in_key = 128'h0; in_block = 128'h0; rst_n = 1'b0;
    test_reset();
    encrypt(0, KEY1, PT1, CT1, 10, 1'b0, "t1_u1");
    encrypt(1, KEY2, PT2, CT2, 5, 1'b0, "t3_u2");
    encrypt(2, KEY2, PT2, CT2, 2, 1'b0, "t3_u5");
    encrypt(3, KEY2, PT2, CT2, 1, 1'b0, "t3_u10");
    encrypt(0, 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 10, 1'b0, "zero_u1");
    test_backpressure();
    test_reset_mid_run();
    encrypt(0, KEY1, PT1, CT1, 10, 1'b1, "t6_u1");
    encrypt(3, KEY1, PT1, CT1, 1, 1'b1, "t6_u10");
`ifdef AES_ROUND_TAP_EN
    test_tap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
